// File: rtl/control_unit_of_processor_pkg.sv
// Shared constants for the instruction-sequencing control unit:
// opcodes, state encoding and one-hot bus select codes.
package control_unit_of_processor_pkg;

    typedef enum logic [1:0] {
        T0 = 2'd0,
        T1 = 2'd1,
        T2 = 2'd2,
        T3 = 2'd3
    } state_t;

    localparam logic [1:0] OP_MV  = 2'b00;
    localparam logic [1:0] OP_MVI = 2'b01;
    localparam logic [1:0] OP_ADD = 2'b10;
    localparam logic [1:0] OP_SUB = 2'b11;

    // Bus select: bit0=G, bit1..4=R0..R3, bit5=DIN.
    localparam logic [5:0] SEL_G   = 6'b000001;
    localparam logic [5:0] SEL_R0  = 6'b000010;
    localparam logic [5:0] SEL_R1  = 6'b000100;
    localparam logic [5:0] SEL_R2  = 6'b001000;
    localparam logic [5:0] SEL_R3  = 6'b010000;
    localparam logic [5:0] SEL_DIN = 6'b100000;

endpackage

// File: rtl/control_unit_of_processor_if.sv
// Control-unit to datapath connection: start/instruction inputs and the
// bus select, load enables, ALU mode and completion outputs.
interface control_unit_of_processor_if;
    logic       Run;
    logic [7:0] DIN;
    logic [5:0] S;
    logic       R0in;
    logic       R1in;
    logic       R2in;
    logic       R3in;
    logic       Ain;
    logic       Gin;
    logic       Mode;
    logic       Done;

    modport master (
        input  Run, DIN,
        output S, R0in, R1in, R2in, R3in, Ain, Gin, Mode, Done
    );

    modport slave (
        output Run, DIN,
        input  S, R0in, R1in, R2in, R3in, Ain, Gin, Mode, Done
    );
endinterface

// File: rtl/control_unit_of_processor_reg_select_decoder.sv
// Maps a 2-bit register index to its one-hot load enable (R0..R3)
// and the matching one-hot bus select code.
module reg_select_decoder
    import control_unit_of_processor_pkg::*;
(
    input  logic [1:0] idx,
    output logic [3:0] load_en,
    output logic [5:0] bus_sel
);
    assign load_en = 4'b0001 << idx;
    assign bus_sel = SEL_R0 << idx;
endmodule

// File: rtl/control_unit_of_processor.sv
// Instruction-sequencing FSM for the 8-bit processor datapath; fetches
// from DIN on Run in T0 and drives registered bus/enable/mode outputs.
module control_unit_of_processor
    import control_unit_of_processor_pkg::*;
(
    input  logic                                Clk,
    input  logic                                Resetn,
    control_unit_of_processor_if.master         bus,
    output state_t                              state_dbg,
    output logic [7:0]                          ir_dbg
);
    state_t     state;
    logic [7:0] ir;
    logic [5:0] s_q;
    logic [3:0] en_q;
    logic       ain_q, gin_q, mode_q, done_q;

    // In T0 the outputs for T1 are decoded from the word being fetched.
    logic [1:0] op_src, x_src, y_src;
    assign op_src = (state == T0) ? bus.DIN[7:6] : ir[7:6];
    assign x_src  = (state == T0) ? bus.DIN[5:4] : ir[5:4];
    assign y_src  = (state == T0) ? bus.DIN[3:2] : ir[3:2];

    logic [3:0] x_en, unused_y_en;
    logic [5:0] x_sel, y_sel;

    reg_select_decoder u_dec_x (.idx(x_src), .load_en(x_en),        .bus_sel(x_sel));
    reg_select_decoder u_dec_y (.idx(y_src), .load_en(unused_y_en), .bus_sel(y_sel));

    always_ff @(posedge Clk or negedge Resetn) begin
        if (!Resetn) begin
            state  <= T0;
            ir     <= 8'h00;
            s_q    <= SEL_DIN;
            en_q   <= 4'b0000;
            ain_q  <= 1'b0;
            gin_q  <= 1'b0;
            mode_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            s_q    <= SEL_DIN;
            en_q   <= 4'b0000;
            ain_q  <= 1'b0;
            gin_q  <= 1'b0;
            mode_q <= 1'b0;
            done_q <= 1'b0;
            case (state)
                T0: begin
                    if (bus.Run) begin
                        ir    <= bus.DIN;
                        state <= T1;
                        case (op_src)
                            OP_MV: begin
                                s_q    <= y_sel;
                                en_q   <= x_en;
                                done_q <= 1'b1;
                            end
                            OP_MVI: begin
                                en_q   <= x_en;
                                done_q <= 1'b1;
                            end
                            default: begin
                                s_q   <= x_sel;
                                ain_q <= 1'b1;
                            end
                        endcase
                    end
                end
                T1: begin
                    if (op_src == OP_MV || op_src == OP_MVI) begin
                        state <= T0;
                    end else begin
                        state  <= T2;
                        s_q    <= y_sel;
                        gin_q  <= 1'b1;
                        mode_q <= ir[6];
                    end
                end
                T2: begin
                    state  <= T3;
                    s_q    <= SEL_G;
                    en_q   <= x_en;
                    done_q <= 1'b1;
                end
                default: state <= T0;
            endcase
        end
    end

    assign bus.S    = s_q;
    assign bus.R0in = en_q[0];
    assign bus.R1in = en_q[1];
    assign bus.R2in = en_q[2];
    assign bus.R3in = en_q[3];
    assign bus.Ain  = ain_q;
    assign bus.Gin  = gin_q;
    assign bus.Mode = mode_q;
    assign bus.Done = done_q;

    assign state_dbg = state;
    assign ir_dbg    = ir;
endmodule

// File: tb/tb_control_unit_of_processor.sv
// Directed bench for control_unit_of_processor with an attached behavioural
// datapath model; per-cycle expected outputs go through a scoreboard queue.
module tb_control_unit_of_processor;
  import control_unit_of_processor_pkg::*;

  logic Clk;
  logic Resetn;
  state_t state_dbg;
  logic [7:0] ir_dbg;

  control_unit_of_processor_if bus ();

  control_unit_of_processor dut (
    .Clk       (Clk),
    .Resetn    (Resetn),
    .bus       (bus),
    .state_dbg (state_dbg),
    .ir_dbg    (ir_dbg)
  );

  // clock / reset
  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  // output word: {S, R3in, R2in, R1in, R0in, Ain, Gin, Mode, Done}
  localparam logic [13:0] IDLE = {SEL_DIN, 8'h00};

  function automatic logic [13:0] mk(logic [5:0] s, logic [3:0] en, logic ain,
                                     logic gin, logic mode, logic done);
    return {s, en, ain, gin, mode, done};
  endfunction

  function automatic logic [13:0] out_word();
    return {bus.S, bus.R3in, bus.R2in, bus.R1in, bus.R0in,
            bus.Ain, bus.Gin, bus.Mode, bus.Done};
  endfunction

  // behavioural datapath: R0..R3, A, G and the bus mux
  logic [7:0] dp_r [4] = '{default: 8'h00};
  logic [7:0] dp_a = 8'h00;
  logic [7:0] dp_g = 8'h00;
  logic [7:0] dp_bus;

  always_comb begin
    dp_bus = 8'h00;
    case (bus.S)
      6'b000001: dp_bus = dp_g;
      6'b000010: dp_bus = dp_r[0];
      6'b000100: dp_bus = dp_r[1];
      6'b001000: dp_bus = dp_r[2];
      6'b010000: dp_bus = dp_r[3];
      6'b100000: dp_bus = bus.DIN;
      default:   dp_bus = 8'h00;
    endcase
  end

  always @(posedge Clk) begin
    if (bus.R0in) dp_r[0] <= dp_bus;
    if (bus.R1in) dp_r[1] <= dp_bus;
    if (bus.R2in) dp_r[2] <= dp_bus;
    if (bus.R3in) dp_r[3] <= dp_bus;
    if (bus.Ain)  dp_a    <= dp_bus;
    if (bus.Gin)  dp_g    <= bus.Mode ? (dp_a - dp_bus) : (dp_a + dp_bus);
  end

  // scoreboard
  logic [13:0] exp_q [$];
  int checks = 0;
  int errors = 0;

  task automatic chk_out(input string tag);
    logic [13:0] exp_w;
    logic [13:0] act_w;
    exp_w = exp_q.pop_front();
    act_w = out_word();
    checks++;
    assert (act_w === exp_w) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, act_w, exp_w);
    end
  endtask

  task automatic chk_val(input string tag, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    assert (act === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, act, exp);
    end
  endtask

  // driver: apply inputs on the falling edge, check just after the rising edge
  task automatic step(input logic run, input logic [7:0] din,
                      input logic [13:0] exp, input string tag);
    @(negedge Clk);
    bus.Run = run;
    bus.DIN = din;
    exp_q.push_back(exp);
    @(posedge Clk);
    #1;
    chk_out(tag);
  endtask

  function automatic logic rnd_bit();
    return 1'($urandom_range(0, 1));
  endfunction

  function automatic logic [7:0] rnd_byte();
    return 8'($urandom_range(0, 255));
  endfunction

  task automatic load_imm(input logic [7:0] instr, input logic [7:0] imm,
                          input logic [3:0] en, input string tag);
    step(1'b1, instr, mk(SEL_DIN, en, 1'b0, 1'b0, 1'b0, 1'b1), tag);
    step(1'b0, imm, IDLE, {tag, "_idle"});
  endtask

  initial begin
    // reset held with Run high and an all-ones instruction
    Resetn  = 1'b0;
    bus.Run = 1'b1;
    bus.DIN = 8'hFF;
    repeat (2) @(posedge Clk);
    #1;
    exp_q.push_back(IDLE);
    chk_out("reset_idle");
    chk_val("reset_state", {6'b0, state_dbg}, 8'h00);
    chk_val("reset_ir", ir_dbg, 8'h00);

    @(negedge Clk);
    Resetn  = 1'b1;
    bus.Run = 1'b0;
    step(1'b0, 8'hFF, IDLE, "run_low_idle0");
    step(1'b0, 8'h60, IDLE, "run_low_idle1");

    // mvi R2,#5A
    load_imm(8'h60, 8'h5A, 4'b0100, "mvi_r2");
    chk_val("r2_after_mvi", dp_r[2], 8'h5A);

    // mv R0,R3 (R3 still zero)
    step(1'b1, 8'h0C, mk(SEL_R3, 4'b0001, 1'b0, 1'b0, 1'b0, 1'b1), "mv_r0_r3_t1");
    step(1'b0, rnd_byte(), IDLE, "mv_r0_r3_idle");
    chk_val("r0_after_mv", dp_r[0], 8'h00);

    // sub R1,R2 with R1=05, R2=07; Run toggled while busy
    load_imm(8'h50, 8'h05, 4'b0010, "mvi_r1");
    load_imm(8'h60, 8'h07, 4'b0100, "mvi_r2b");
    step(1'b1, 8'hD8, mk(SEL_R1, 4'b0000, 1'b1, 1'b0, 1'b0, 1'b0), "sub_t1");
    step(1'b1, 8'h4C, mk(SEL_R2, 4'b0000, 1'b0, 1'b1, 1'b1, 1'b0), "sub_t2");
    step(1'b0, rnd_byte(), mk(SEL_G, 4'b0010, 1'b0, 1'b0, 1'b0, 1'b1), "sub_t3");
    step(1'b1, 8'h0C, IDLE, "sub_done_idle");
    chk_val("r1_after_sub", dp_r[1], 8'hFE);
    step(1'b0, rnd_byte(), IDLE, "sub_post_idle");

    // back-to-back: add R3,R3 (R3=81) then mv R0,R3 with Run held high
    load_imm(8'h70, 8'h81, 4'b1000, "mvi_r3");
    step(1'b1, 8'hBC, mk(SEL_R3, 4'b0000, 1'b1, 1'b0, 1'b0, 1'b0), "add_t1");
    step(1'b1, rnd_byte(), mk(SEL_R3, 4'b0000, 1'b0, 1'b1, 1'b0, 1'b0), "add_t2");
    step(1'b1, rnd_byte(), mk(SEL_G, 4'b1000, 1'b0, 1'b0, 1'b0, 1'b1), "add_t3");
    step(1'b1, 8'h0C, IDLE, "b2b_t0");
    chk_val("r3_after_add", dp_r[3], 8'h02);
    step(1'b1, 8'h0C, mk(SEL_R3, 4'b0001, 1'b0, 1'b0, 1'b0, 1'b1), "b2b_mv_t1");
    step(rnd_bit(), 8'hFF, IDLE, "b2b_mv_idle");
    chk_val("r0_after_b2b", dp_r[0], 8'h02);
    chk_val("ir_after_b2b", ir_dbg, 8'h0C);
    step(1'b0, 8'hFF, IDLE, "b2b_quiet");

    // asynchronous reset during T2 of add R1,R1
    step(1'b1, 8'h94, mk(SEL_R1, 4'b0000, 1'b1, 1'b0, 1'b0, 1'b0), "abort_t1");
    step(1'b0, rnd_byte(), mk(SEL_R1, 4'b0000, 1'b0, 1'b1, 1'b0, 1'b0), "abort_t2");
    #1;
    Resetn = 1'b0;
    #1;
    exp_q.push_back(IDLE);
    chk_out("abort_async_idle");
    chk_val("abort_state", {6'b0, state_dbg}, 8'h00);
    chk_val("abort_ir", ir_dbg, 8'h00);
    @(negedge Clk);
    Resetn  = 1'b1;
    bus.Run = 1'b0;
    step(1'b0, rnd_byte(), IDLE, "abort_after0");
    step(1'b0, rnd_byte(), IDLE, "abort_after1");
    step(1'b0, rnd_byte(), IDLE, "abort_after2");
    chk_val("r1_after_abort", dp_r[1], 8'hFE);

    // first fetch after release still works
    step(1'b1, 8'h1C, mk(SEL_R3, 4'b0010, 1'b0, 1'b0, 1'b0, 1'b1), "post_abort_mv");
    step(1'b0, 8'h00, IDLE, "post_abort_idle");
    chk_val("r1_after_mv", dp_r[1], 8'h02);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
